// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared encodings and defaults for the sequence-scan arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int SEQ_W = 8;
    localparam int SEQ_N = 4;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } arb_state_t;

    // Each state names the longest prefix of 10010 matched so far.
    typedef enum logic [2:0] {
        DET_IDLE = 3'd0,
        DET_1    = 3'd1,
        DET_10   = 3'd2,
        DET_100  = 3'd3,
        DET_1001 = 3'd4,
        DET_HIT  = 3'd5
    } det_state_t;

    // First requester found searching upward from last_id+1, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last_id);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last_id;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_id + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_core.sv
// ============================================================================
// Module  : seq_det_core
// Brief   : Moore detector for 10010 (overlapping) with a registered hit flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_core
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic seq,
    output logic flag
);

    det_state_t state_q, state_d;
    logic       flag_q, flag_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_IDLE: state_d = seq ? DET_1    : DET_IDLE;
            DET_1:    state_d = seq ? DET_1    : DET_10;
            // A hit leaves "10" as the live suffix, so HIT steps like DET_10.
            DET_10,
            DET_HIT:  state_d = seq ? DET_1    : DET_100;
            DET_100:  state_d = seq ? DET_1001 : DET_IDLE;
            DET_1001: state_d = seq ? DET_1    : DET_HIT;
            default:  state_d = DET_IDLE;
        endcase
        if (clr) begin
            state_d = DET_IDLE;
        end
        flag_d = (state_d == DET_HIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DET_IDLE;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

`default_nettype wire

// File: rtl/seq_scan_arbiter.sv
// ============================================================================
// Module  : seq_scan_arbiter
// Brief   : Round-robin sharing of one serial 10010 detector among 4 requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_arbiter
    import seq_pkg::*;
#(
    parameter int W = SEQ_W,
    parameter int N = SEQ_N
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         data,
    output logic [N-1:0]           grant,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             done_id,
    output logic [$clog2(W+1)-1:0] match_cnt
);

    localparam int            CW       = $clog2(W + 1);
    localparam int            BW       = $clog2(W);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic f);
        if (f && (c != {CW{1'b1}})) begin
            return c + CW'(1);
        end
        return c;
    endfunction

    arb_state_t    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [1:0]    done_id_q, done_id_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_id_q, last_id_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [1:0]    win;
    logic          accept;
    logic          det_flag;

    assign accept = (state_q == ST_IDLE) && (|req);
    assign win    = rr_pick(req, last_id_q);

    // Clearing on the accept edge guarantees no pattern straddles two words.
    seq_det_core u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .seq   (shift_q[W-1]),
        .flag  (det_flag)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        owner_d     = owner_q;
        last_id_d   = last_id_q;
        match_cnt_d = match_cnt_q;
        count_d     = count_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d      = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    shift_d      = data[int'(win)*W +: W];
                    count_d      = '0;
                    bit_idx_d    = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The flag seen here belongs to the bit consumed one edge earlier.
                count_d = sat_inc(count_q, det_flag);
                shift_d = shift_q << 1;
                if (bit_idx_q == LAST_BIT) begin
                    state_d = ST_DRAIN;
                end else begin
                    bit_idx_d = bit_idx_q + BW'(1);
                end
            end
            ST_DRAIN: begin
                match_cnt_d = sat_inc(count_q, det_flag);
                done_id_d   = owner_q;
                done_d      = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                grant_d   = '0;
                busy_d    = 1'b0;
                last_id_d = owner_q;
                state_d   = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            owner_q     <= '0;
            last_id_q   <= 2'd3;
            match_cnt_q <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            owner_q     <= owner_d;
            last_id_q   <= last_id_d;
            match_cnt_q <= match_cnt_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

`default_nettype wire
